// File: rtl/char_grid_display_if.sv
// Pixel query, character-buffer write port and per-pixel result bundle.
// Latency: none; this is wiring only.
// Backpressure: none; every signal is sampled or produced on each clock.
interface char_grid_display_if #(
  parameter int COLS   = 8,
  parameter int ROWS   = 2,
  parameter int ADDR_W = 19
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [9:0]        x;
  logic [8:0]        y;
  logic              frame_tick;
  logic              wr_en;
  logic [RW-1:0]     wr_row;
  logic [CW-1:0]     wr_col;
  logic [7:0]        wr_char;
  logic [1:0]        wr_attr;
  logic [ROWS-1:0]   scroll_en;
  logic              hl_en;

  logic              in_grid;
  logic              visible;
  logic              highlight;
  logic [RW-1:0]     row_id;
  logic [7:0]        char;
  logic [ADDR_W-1:0] sprite_addr;

  modport master (
    output x, y, frame_tick, wr_en, wr_row, wr_col, wr_char, wr_attr, scroll_en, hl_en,
    input  in_grid, visible, highlight, row_id, char, sprite_addr
  );

  modport slave (
    input  x, y, frame_tick, wr_en, wr_row, wr_col, wr_char, wr_attr, scroll_en, hl_en,
    output in_grid, visible, highlight, row_id, char, sprite_addr
  );
endinterface

// File: rtl/char_grid_display.sv
// Character-grid overlay: hit-tests the pixel, looks up the (scrolled) cell, emits sprite address.
// Latency: 2 cycles from x/y to outputs; buffer writes land in the same edge they are strobed.
// Backpressure: none; one pixel accepted every cycle.
module char_grid_display #(
  parameter int COLS          = 8,
  parameter int ROWS          = 2,
  parameter int CELL_W        = 50,
  parameter int CELL_H        = 50,
  parameter int X0            = 120,
  parameter int Y0            = 25,
  parameter int ROW_PITCH     = 190,
  parameter int CHAR_BASE     = 33,
  parameter int ADDR_W        = 19,
  parameter int BLINK_FRAMES  = 30,
  parameter int SCROLL_FRAMES = 15
) (
  input logic              clk,
  input logic              reset,
  char_grid_display_if.slave g
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  // character buffer and marquee state
  logic [7:0]    buf_code_q [ROWS][COLS];
  logic [7:0]    buf_code_d [ROWS][COLS];
  logic [1:0]    buf_attr_q [ROWS][COLS];
  logic [1:0]    buf_attr_d [ROWS][COLS];
  logic [CW-1:0] pos_q [ROWS];
  logic [CW-1:0] pos_d [ROWS];
  logic [15:0]   scroll_cnt_q, scroll_cnt_d;
  logic [15:0]   blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          scroll_step;

  // stage 1
  logic          row_hit, col_hit;
  logic          s1_hit_q, s1_hit_d;
  logic [RW-1:0] s1_row_q, s1_row_d;
  logic [CW-1:0] s1_col_q, s1_col_d;
  logic [9:0]    s1_lx_q, s1_lx_d;
  logic [8:0]    s1_ly_q, s1_ly_d;

  // stage 2
  logic [CW:0]       col_raw;
  logic [CW-1:0]     sel_col;
  logic [7:0]        cell_code;
  logic [1:0]        cell_attr;
  logic              vis;
  logic              in_grid_q, in_grid_d;
  logic              visible_q, visible_d;
  logic              highlight_q, highlight_d;
  logic [RW-1:0]     row_id_q, row_id_d;
  logic [7:0]        char_q, char_d;
  logic [ADDR_W-1:0] sprite_addr_q, sprite_addr_d;

  // Frame dividers: the scroll step and blink toggle both fire on the wrapping tick.
  always_comb begin
    scroll_step   = g.frame_tick && (scroll_cnt_q == 16'(SCROLL_FRAMES - 1));
    scroll_cnt_d  = scroll_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (g.frame_tick) begin
      scroll_cnt_d = scroll_step ? 16'd0 : scroll_cnt_q + 16'd1;
      if (blink_cnt_q == 16'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = 16'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
  end

  // Buffer write (out-of-range indices dropped) and per-row marquee position.
  always_comb begin
    buf_code_d = buf_code_q;
    buf_attr_d = buf_attr_q;
    if (g.wr_en && (32'(g.wr_row) < 32'(ROWS)) && (32'(g.wr_col) < 32'(COLS))) begin
      buf_code_d[g.wr_row][g.wr_col] = g.wr_char;
      buf_attr_d[g.wr_row][g.wr_col] = g.wr_attr;
    end
    for (int r = 0; r < ROWS; r++) begin
      pos_d[r] = pos_q[r];
      if (!g.scroll_en[r]) begin
        pos_d[r] = '0;
      end else if (scroll_step) begin
        pos_d[r] = (32'(pos_q[r]) == 32'(COLS - 1)) ? '0 : pos_q[r] + 1'b1;
      end
    end
  end

  // Stage 1 hit test; cells never overlap, so at most one row and one column match.
  always_comb begin
    row_hit  = 1'b0;
    col_hit  = 1'b0;
    s1_row_d = '0;
    s1_col_d = '0;
    s1_lx_d  = '0;
    s1_ly_d  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if ((32'(g.y) >= 32'(Y0 + r * ROW_PITCH)) && (32'(g.y) < 32'(Y0 + r * ROW_PITCH + CELL_H))) begin
        row_hit  = 1'b1;
        s1_row_d = RW'(r);
        s1_ly_d  = 9'(32'(g.y) - 32'(Y0 + r * ROW_PITCH));
      end
    end
    for (int c = 0; c < COLS; c++) begin
      if ((32'(g.x) >= 32'(X0 + c * CELL_W)) && (32'(g.x) < 32'(X0 + (c + 1) * CELL_W))) begin
        col_hit  = 1'b1;
        s1_col_d = CW'(c);
        s1_lx_d  = 10'(32'(g.x) - 32'(X0 + c * CELL_W));
      end
    end
    s1_hit_d = row_hit && col_hit;
  end

  // Stage 2: scrolled buffer lookup and output formation.
  always_comb begin
    col_raw   = (CW+1)'(s1_col_q) + (CW+1)'(pos_q[s1_row_q]);
    sel_col   = (col_raw >= (CW+1)'(COLS)) ? CW'(col_raw - (CW+1)'(COLS)) : CW'(col_raw);
    cell_code = buf_code_q[s1_row_q][sel_col];
    cell_attr = buf_attr_q[s1_row_q][sel_col];
    vis       = s1_hit_q && (32'(cell_code) >= 32'(CHAR_BASE)) && !(cell_attr[1] && blink_phase_q);
    in_grid_d     = s1_hit_q;
    visible_d     = vis;
    highlight_d   = s1_hit_q && g.hl_en && cell_attr[0];
    row_id_d      = s1_hit_q ? s1_row_q : '0;
    char_d        = vis ? cell_code : 8'd0;
    sprite_addr_d = '0;
    if (vis) begin
      sprite_addr_d = ADDR_W'((32'(cell_code) - 32'(CHAR_BASE)) * 32'(CELL_W * CELL_H)
                              + 32'(s1_ly_q) * 32'(CELL_W) + 32'(s1_lx_q));
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++) begin
        pos_q[r] <= '0;
        for (int c = 0; c < COLS; c++) begin
          buf_code_q[r][c] <= '0;
          buf_attr_q[r][c] <= '0;
        end
      end
      scroll_cnt_q  <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      s1_hit_q      <= 1'b0;
      s1_row_q      <= '0;
      s1_col_q      <= '0;
      s1_lx_q       <= '0;
      s1_ly_q       <= '0;
      in_grid_q     <= 1'b0;
      visible_q     <= 1'b0;
      highlight_q   <= 1'b0;
      row_id_q      <= '0;
      char_q        <= '0;
      sprite_addr_q <= '0;
    end else begin
      buf_code_q    <= buf_code_d;
      buf_attr_q    <= buf_attr_d;
      pos_q         <= pos_d;
      scroll_cnt_q  <= scroll_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      s1_hit_q      <= s1_hit_d;
      s1_row_q      <= s1_row_d;
      s1_col_q      <= s1_col_d;
      s1_lx_q       <= s1_lx_d;
      s1_ly_q       <= s1_ly_d;
      in_grid_q     <= in_grid_d;
      visible_q     <= visible_d;
      highlight_q   <= highlight_d;
      row_id_q      <= row_id_d;
      char_q        <= char_d;
      sprite_addr_q <= sprite_addr_d;
    end
  end

  assign g.in_grid     = in_grid_q;
  assign g.visible     = visible_q;
  assign g.highlight   = highlight_q;
  assign g.row_id      = row_id_q;
  assign g.char        = char_q;
  assign g.sprite_addr = sprite_addr_q;
endmodule

// File: tb/tb_char_grid_display.sv
// Bench for char_grid_display: directed steps then randomized traffic against a tick-count model.
module tb_char_grid_display;
  localparam int COLS = 8, ROWS = 2, CELL_W = 50, CELL_H = 50, X0 = 120, Y0 = 25;
  localparam int ROW_PITCH = 190, CHAR_BASE = 33, ADDR_W = 19, BLINK_FRAMES = 30, SCROLL_FRAMES = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  char_grid_display_if #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) g ();

  char_grid_display #(
    .COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .CELL_H(CELL_H), .X0(X0), .Y0(Y0),
    .ROW_PITCH(ROW_PITCH), .CHAR_BASE(CHAR_BASE), .ADDR_W(ADDR_W),
    .BLINK_FRAMES(BLINK_FRAMES), .SCROLL_FRAMES(SCROLL_FRAMES)
  ) dut (
    .clk(clk),
    .reset(rst),
    .g(g)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference state: buffer contents, marquee offsets and total frame ticks seen
  int m_code [ROWS][COLS];
  int m_attr [ROWS][COLS];
  int m_pos  [ROWS];
  int n_ticks;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) begin
      m_pos[r] = 0;
      for (int c = 0; c < COLS; c++) begin
        m_code[r][c] = 0;
        m_attr[r][c] = 0;
      end
    end
    n_ticks = 0;
  endtask

  // one rising edge; the model absorbs whatever inputs were presented to it
  task automatic cyc();
    @(posedge clk);
    if (g.wr_en) begin
      m_code[g.wr_row][g.wr_col] = int'(g.wr_char);
      m_attr[g.wr_row][g.wr_col] = int'(g.wr_attr);
    end
    if (g.frame_tick) n_ticks++;
    for (int r = 0; r < ROWS; r++) begin
      if (!g.scroll_en[r]) m_pos[r] = 0;
      else if (g.frame_tick && (n_ticks % SCROLL_FRAMES == 0)) m_pos[r] = (m_pos[r] + 1) % COLS;
    end
  endtask

  task automatic write(int row, int col, int ch, int attr, bit tick);
    @(negedge clk);
    g.wr_en = 1'b1;
    g.wr_row = 1'(row);
    g.wr_col = 3'(col);
    g.wr_char = 8'(ch);
    g.wr_attr = 2'(attr);
    g.frame_tick = tick;
    cyc();
    @(negedge clk);
    g.wr_en = 1'b0;
    g.frame_tick = 1'b0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g.frame_tick = 1'b1;
      cyc();
      @(negedge clk);
      g.frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic pixel(int px, int py);
    bit hit;
    int r, c, lx, ly, code, attr, blink;
    int e_vis, e_hl, e_row, e_char, e_addr;
    @(negedge clk);
    g.x = 10'(px);
    g.y = 9'(py);
    cyc();
    cyc();
    #1;
    hit = 0; r = 0; c = 0; lx = 0; ly = 0; code = 0; attr = 0;
    if (px >= X0 && px < X0 + COLS * CELL_W && py >= Y0) begin
      c  = (px - X0) / CELL_W;
      lx = (px - X0) % CELL_W;
      r  = (py - Y0) / ROW_PITCH;
      ly = (py - Y0) % ROW_PITCH;
      hit = (r < ROWS) && (ly < CELL_H);
    end
    if (hit) begin
      code = m_code[r][(c + m_pos[r]) % COLS];
      attr = m_attr[r][(c + m_pos[r]) % COLS];
    end
    blink  = (n_ticks / BLINK_FRAMES) % 2;
    e_vis  = (hit && code >= CHAR_BASE && !(((attr >> 1) & 1) == 1 && blink == 1)) ? 1 : 0;
    e_hl   = (hit && g.hl_en && (attr & 1) == 1) ? 1 : 0;
    e_row  = hit ? r : 0;
    e_char = e_vis ? code : 0;
    e_addr = e_vis ? ((code - CHAR_BASE) * CELL_W * CELL_H + ly * CELL_W + lx) % (1 << ADDR_W) : 0;
    chk($sformatf("in_grid(%0d,%0d)", px, py), 32'(g.in_grid), hit ? 32'd1 : 32'd0);
    chk($sformatf("visible(%0d,%0d)", px, py), 32'(g.visible), 32'(e_vis));
    chk($sformatf("highlight(%0d,%0d)", px, py), 32'(g.highlight), 32'(e_hl));
    chk($sformatf("row_id(%0d,%0d)", px, py), 32'(g.row_id), 32'(e_row));
    chk($sformatf("char(%0d,%0d)", px, py), 32'(g.char), 32'(e_char));
    chk($sformatf("sprite_addr(%0d,%0d)", px, py), 32'(g.sprite_addr), 32'(e_addr));
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_in_grid"}, 32'(g.in_grid), 32'd0);
    chk({tag, "_visible"}, 32'(g.visible), 32'd0);
    chk({tag, "_highlight"}, 32'(g.highlight), 32'd0);
    chk({tag, "_row_id"}, 32'(g.row_id), 32'd0);
    chk({tag, "_char"}, 32'(g.char), 32'd0);
    chk({tag, "_addr"}, 32'(g.sprite_addr), 32'd0);
  endtask

  initial begin
    int op, px, py;
    g.x = '0; g.y = '0; g.frame_tick = 1'b0; g.wr_en = 1'b0; g.wr_row = '0; g.wr_col = '0;
    g.wr_char = '0; g.wr_attr = '0; g.scroll_en = '0; g.hl_en = 1'b1;
    g.x = 10'd123; g.y = 9'd27;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");

    @(negedge clk);
    rst = 1'b1;

    // basic hit and address
    write(0, 0, 65, 0, 1'b0);
    pixel(123, 27);
    chk("first_char", 32'(g.char), 32'd65);
    chk("first_addr", 32'(g.sprite_addr), 32'd80103);

    // cell edges on both axes
    pixel(170, 27);
    pixel(169, 27);
    pixel(119, 27);
    chk("left_edge_miss", 32'(g.in_grid), 32'd0);
    pixel(123, 74);
    pixel(123, 75);
    chk("bottom_edge_miss", 32'(g.in_grid), 32'd0);
    pixel(519, 74);
    pixel(520, 74);

    // highlight gating and sub-base code
    write(0, 1, 66, 1, 1'b0);
    pixel(170, 27);
    chk("hl_on", 32'(g.highlight), 32'd1);
    @(negedge clk); g.hl_en = 1'b0;
    pixel(170, 27);
    chk("hl_off", 32'(g.highlight), 32'd0);
    @(negedge clk); g.hl_en = 1'b1;
    write(0, 2, 20, 0, 1'b0);
    pixel(220, 27);

    // blink half-periods
    write(0, 3, 67, 2, 1'b0);
    pixel(270, 27);
    ticks(30);
    pixel(270, 27);
    chk("blink_off", 32'(g.visible), 32'd0);
    ticks(30);
    pixel(270, 27);
    chk("blink_on", 32'(g.visible), 32'd1);

    // marquee on row 1
    for (int c = 0; c < COLS; c++) write(1, c, 65 + c, 0, 1'b0);
    @(negedge clk); g.scroll_en = 2'b10;
    cyc();
    ticks(15);
    pixel(123, 217);
    chk("scroll_1", 32'(g.char), 32'd66);
    ticks(105);
    pixel(123, 217);
    chk("scroll_wrap", 32'(g.char), 32'd65);
    ticks(15);
    pixel(123, 217);
    @(negedge clk); g.scroll_en = 2'b00;
    pixel(123, 217);
    chk("scroll_drop", 32'(g.char), 32'd65);

    // write and tick on the same edge
    write(0, 4, 90, 3, 1'b1);
    pixel(320, 27);

    // reset in the middle of a line
    pixel(123, 27);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk_all_zero("reset_mid");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    pixel(123, 27);
    chk("after_reset_vis", 32'(g.visible), 32'd0);

    // randomized traffic
    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 6));
      case (op)
        0, 1: write(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)),
                    int'($urandom_range(0, 127)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        2: ticks(int'($urandom_range(1, 20)));
        3: begin
          @(negedge clk);
          g.scroll_en = 2'($urandom_range(0, 3));
          g.hl_en = 1'($urandom_range(0, 1));
          cyc();
        end
        default: begin
          if ($urandom_range(0, 3) != 0) begin
            px = X0 + int'($urandom_range(0, COLS - 1)) * CELL_W + int'($urandom_range(0, CELL_W - 1));
            py = Y0 + int'($urandom_range(0, ROWS - 1)) * ROW_PITCH + int'($urandom_range(0, CELL_H));
            if ($urandom_range(0, 4) == 0) px = px - 1;
          end else begin
            px = int'($urandom_range(0, 639));
            py = int'($urandom_range(0, 479));
          end
          pixel(px, py);
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
